// File: rtl/jtframe_dwnld_pkg.sv
// jtframe_dwnld_pkg: shared types and constants for the ioctl-to-SDRAM download path
package jtframe_dwnld_pkg;

    typedef struct packed {
        logic [1:0]  bank;
        logic [21:0] waddr;
        logic        lane;
        logic [7:0]  data;
    } fifo_entry_t;

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_BOTH = 2'b00;

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// jtframe_dwnld_fifo: 2**AW deep FIFO of download entries with single/dual pop
// ports: clk, rst (async high), push/din (ignored when full), pop, pop2 (drop two),
//        empty, full, has2 (two or more entries), head, next (entry behind head)
module jtframe_dwnld_fifo
    import jtframe_dwnld_pkg::*;
#(
    parameter int AW = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fifo_entry_t din,
    input  logic        pop,
    input  logic        pop2,
    output logic        empty,
    output logic        full,
    output logic        has2,
    output fifo_entry_t head,
    output fifo_entry_t next
);
    fifo_entry_t    mem [2**AW];
    logic [AW-1:0]  rd, wr;
    logic [AW:0]    cnt, npop;
    logic           push_ok;

    assign empty   = cnt == '0;
    assign full    = cnt == (AW+1)'(2**AW);
    assign has2    = cnt > (AW+1)'(1);
    assign push_ok = push & ~full;
    assign npop    = pop2 ? (AW+1)'(2) : {{AW{1'b0}}, pop};
    assign head    = mem[rd];
    assign next    = mem[rd + 1'b1];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else begin
            wr  <= wr + {{(AW-1){1'b0}}, push_ok};
            rd  <= rd + npop[AW-1:0];
            cnt <= cnt + {{AW{1'b0}}, push_ok} - npop;
        end

    always_ff @(posedge clk)
        if (push_ok) mem[wr] <= din;

endmodule

// File: rtl/jtframe_ioctl_prog.sv
// jtframe_ioctl_prog: turns the ioctl byte download stream into 16-bit SDRAM programming writes
// ports: clk_rom, rst (async high); downloading/ioctl_addr/ioctl_data/ioctl_wr from the I/O controller;
//        prog_addr/prog_data/prog_mask/prog_bank/prog_we to SDRAM, prog_rdy acknowledge;
//        dwnld_busy while downloading or draining; overflow sticky until downloading rises again.
// JTFRAME_DWNLD_MERGE_EN: merge an even/odd byte pair of the same word into one write.
module jtframe_ioctl_prog
    import jtframe_dwnld_pkg::*;
#(
    parameter logic [24:0] BA1_START = 25'h10_0000,
    parameter logic [24:0] BA2_START = 25'h20_0000,
    parameter logic [24:0] BA3_START = 25'h30_0000,
    parameter bit          SWAB      = 1'b0,
    parameter int          AW        = 2
)(
    input  logic        clk_rom,
    input  logic        rst,
    input  logic        downloading,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic [1:0]  prog_bank,
    output logic        prog_we,
    input  logic        prog_rdy,
    output logic        dwnld_busy,
    output logic        overflow
);
`ifdef JTFRAME_DWNLD_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    state_t      state;
    fifo_entry_t din, head, next;
    logic [1:0]  bank;
    logic [24:0] start, off;
    logic        empty, full, has2, push, drop, pop, merge, dl_q;

    assign bank  = ioctl_addr >= BA3_START ? 2'd3 :
                   ioctl_addr >= BA2_START ? 2'd2 :
                   ioctl_addr >= BA1_START ? 2'd1 : 2'd0;
    assign start = bank == 2'd3 ? BA3_START :
                   bank == 2'd2 ? BA2_START :
                   bank == 2'd1 ? BA1_START : '0;
    assign off   = ioctl_addr - start;
    assign din   = '{bank: bank, waddr: 22'(off >> 1), lane: ioctl_addr[0] ^ SWAB, data: ioctl_data};
    assign push  = ioctl_wr & downloading;
    assign drop  = push & full;
    assign merge = MERGE & state == IDLE & has2 & ~head.lane & next.lane &
                   head.bank == next.bank & head.waddr == next.waddr;
    assign pop   = state == IDLE & ~empty & ~merge;

    jtframe_dwnld_fifo #(.AW(AW)) u_fifo (
        .clk   (clk_rom),
        .rst   (rst),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .pop2  (merge),
        .empty (empty),
        .full  (full),
        .has2  (has2),
        .head  (head),
        .next  (next)
    );

    always_ff @(posedge clk_rom or posedge rst)
        if (rst) begin
            state      <= IDLE;
            prog_addr  <= '0;
            prog_data  <= '0;
            prog_mask  <= '0;
            prog_bank  <= '0;
            prog_we    <= 1'b0;
            dwnld_busy <= 1'b0;
            overflow   <= 1'b0;
            dl_q       <= 1'b0;
        end else begin
            dl_q       <= downloading;
            overflow   <= drop | (overflow & ~(downloading & ~dl_q));
            dwnld_busy <= downloading | ~empty | state == WAIT;
            if (state == IDLE) begin
                if (!empty) begin
                    prog_we   <= 1'b1;
                    prog_bank <= head.bank;
                    prog_addr <= head.waddr;
                    prog_data <= merge ? {next.data, head.data} : {2{head.data}};
                    prog_mask <= merge ? MASK_BOTH : head.lane ? MASK_HI : MASK_LO;
                    state     <= WAIT;
                end
            end else if (prog_rdy) begin
                prog_we <= 1'b0;
                state   <= IDLE;
            end
        end

endmodule

// File: tb/tb_jtframe_ioctl_prog.sv
// tb_jtframe_ioctl_prog: directed vector bench for jtframe_ioctl_prog
module tb_jtframe_ioctl_prog;
    logic        clk_rom = 0, rst = 1, downloading = 0, ioctl_wr = 0, prog_rdy = 0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask, prog_bank;
    logic        prog_we, dwnld_busy, overflow;
    int          nvec = 0, nerr = 0;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic [1:0]  bank;
        logic [21:0] waddr;
        logic [1:0]  mask;
    } vec_t;
    vec_t vecs [7];

    jtframe_ioctl_prog dut (
        .clk_rom     (clk_rom),
        .rst         (rst),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wr    (ioctl_wr),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_bank   (prog_bank),
        .prog_we     (prog_we),
        .prog_rdy    (prog_rdy),
        .dwnld_busy  (dwnld_busy),
        .overflow    (overflow)
    );

    always #5 clk_rom = ~clk_rom;

    task automatic tick;
        @(posedge clk_rom);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1;
        tick;
        ioctl_wr   = 0;
    endtask

    task automatic wait_we(input string name);
        int n = 0;
        while (!prog_we && n < 20) begin
            tick;
            n++;
        end
        if (!prog_we) begin
            nvec++;
            nerr++;
            $display("FAIL %s: prog_we never rose, got 0, want 1", name);
        end
    endtask

    task automatic ack;
        repeat (2) begin
            tick;
            chk("we_hold", prog_we, 1);
        end
        prog_rdy = 1;
        tick;
        prog_rdy = 0;
        chk("we_drop", prog_we, 0);
    endtask

    initial begin
        int seen;
        vecs[0] = '{25'h000004,   8'hA5, 2'd0, 22'h000002, 2'b10};
        vecs[1] = '{25'h100001,   8'h3C, 2'd1, 22'h000000, 2'b01};
        vecs[2] = '{25'h300000,   8'h7E, 2'd3, 22'h000000, 2'b10};
        vecs[3] = '{25'h0FFFFF,   8'h11, 2'd0, 22'h07FFFF, 2'b01};
        vecs[4] = '{25'h200003,   8'h22, 2'd2, 22'h000001, 2'b01};
        vecs[5] = '{25'h1FFFFE,   8'h33, 2'd1, 22'h07FFFF, 2'b10};
        vecs[6] = '{25'h1FFFFFF,  8'h44, 2'd3, 22'h27FFFF, 2'b01};

        tick;
        chk("rst_we", prog_we, 0);
        chk("rst_busy", dwnld_busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", {prog_addr, prog_mask, prog_bank}, 0);
        chk("rst_pdata", prog_data, 0);
        rst = 0;
        downloading = 1;
        tick;

        for (int i = 0; i < 7; i++) begin
            push(vecs[i].addr, vecs[i].data);
            wait_we("vec_we");
            chk("vec_bank", prog_bank, vecs[i].bank);
            chk("vec_addr", prog_addr, vecs[i].waddr);
            chk("vec_mask", prog_mask, vecs[i].mask);
            chk("vec_data", prog_data, {vecs[i].data, vecs[i].data});
            chk("vec_busy", dwnld_busy, 1);
            ack;
        end

        chk("ovf_pre", overflow, 0);
        for (int i = 0; i < 6; i++) push(25'h40 + 25'(2 * i), 8'hC0 + 8'(i));
        chk("ovf_set", overflow, 1);
        for (int i = 0; i < 5; i++) begin
            wait_we("ovf_we");
            chk("ovf_data", prog_data, {2{8'hC0 + 8'(i)}});
            ack;
        end
        seen = 0;
        repeat (5) begin
            tick;
            if (prog_we) seen++;
        end
        chk("ovf_dropped", seen, 0);
        chk("ovf_sticky", overflow, 1);
        downloading = 0;
        tick;
        downloading = 1;
        tick;
        chk("ovf_clear", overflow, 0);

        for (int i = 0; i < 4; i++) push(25'h80 + 25'(2 * i), 8'h51 + 8'(i));
        downloading = 0;
        tick;
        chk("drain_busy0", dwnld_busy, 1);
        for (int i = 0; i < 4; i++) begin
            wait_we("drain_we");
            chk("drain_data", prog_data, {2{8'h51 + 8'(i)}});
            chk("drain_busy", dwnld_busy, 1);
            ack;
        end
        chk("drain_busy_last", dwnld_busy, 1);
        tick;
        chk("drain_busy_fall", dwnld_busy, 0);

        push(25'h20, 8'h99);
        repeat (4) tick;
        chk("nodl_we", prog_we, 0);
        chk("nodl_busy", dwnld_busy, 0);

        downloading = 1;
        for (int i = 0; i < 3; i++) push(25'h90 + 25'(2 * i), 8'hD0 + 8'(i));
        wait_we("rst_mid_we");
        rst = 1;
        #1;
        chk("rst_mid_we", prog_we, 0);
        chk("rst_mid_busy", dwnld_busy, 0);
        tick;
        rst = 0;
        seen = 0;
        repeat (5) begin
            tick;
            if (prog_we) seen++;
        end
        chk("rst_mid_empty", seen, 0);
        prog_rdy = 1;
        tick;
        prog_rdy = 0;
        chk("idle_rdy", prog_we, 0);
        push(25'h0A, 8'h77);
        wait_we("post_rst_we");
        chk("post_rst_addr", prog_addr, 22'h5);
        chk("post_rst_data", prog_data, 16'h7777);
        chk("post_rst_mask", prog_mask, 2'b10);
        ack;

        push(25'h40, 8'hEE);
        wait_we("fill_we");
        push(25'h10, 8'h12);
        push(25'h11, 8'h34);
        chk("fill_data", prog_data, 16'hEEEE);
        ack;
        wait_we("pair_we");
        chk("pair_addr0", prog_addr, 22'h8);
`ifdef JTFRAME_DWNLD_MERGE_EN
        chk("merge_data", prog_data, 16'h3412);
        chk("merge_mask", prog_mask, 2'b00);
        ack;
        seen = 0;
        repeat (4) begin
            tick;
            if (prog_we) seen++;
        end
        chk("merge_single", seen, 0);
`else
        chk("pair_data0", prog_data, 16'h1212);
        chk("pair_mask0", prog_mask, 2'b10);
        ack;
        wait_we("pair_we1");
        chk("pair_addr1", prog_addr, 22'h8);
        chk("pair_data1", prog_data, 16'h3434);
        chk("pair_mask1", prog_mask, 2'b01);
        ack;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
